gpu_fetch_ctrl: RTL and testbench
=================================

GPU_FETCH_CTRL -- requirements
Module: gpu_fetch_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: maximum ADDR-state cycles to wait for mem_ack, range 2..255.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  begin or resume fetching; sampled in IDLE, HALT and FAULT only.
REQ-005 halt_req  in  1  request stop after the current instruction completes.
REQ-006 bus_req  out  1  request ownership of the shared 16-bit bus.
REQ-007 bus_gnt  in  1  shared-bus grant from the external arbiter.
REQ-008 read_pc  out  1  drive the PC onto the shared bus as the fetch address.
REQ-009 mem_rd  out  1  instruction memory read strobe.
REQ-010 mem_ack  in  1  instruction word valid on the bus this cycle.
REQ-011 instr_valid  out  1  one-cycle pulse; the external decoder captures the instruction.
REQ-012 instr_len  in  8  decoder output: PC advance in words.
REQ-013 branch_taken  in  1  decoder output: load branch_target instead of advancing.
REQ-014 branch_target  in  13  decoder output: new PC value.
REQ-015 set_pc  out  1  PC load strobe.
REQ-016 inc_pc  out  1  PC advance strobe.
REQ-017 counter_input  out  13  PC load value.
REQ-018 increment_amount  out  8  PC advance value.
REQ-019 halted  out  1  high in HALT state.
REQ-020 fault  out  1  high in FAULT state.

Function
REQ-021 States: IDLE, REQ, ADDR, DECODE, UPDATE, HALT, FAULT; encoding is free.
REQ-022 IDLE: all strobes low; start=1 -> REQ.
REQ-023 REQ: bus_req=1; bus_gnt=1 -> ADDR next cycle.
REQ-024 ADDR: bus_req=1, read_pc=1, mem_rd=1, all held until exit.
- mem_ack=1 -> DECODE.
- bus_gnt=0 with mem_ack=0 -> REQ (read aborted, retried, PC unchanged).
- mem_ack=1 and bus_gnt=0 in the same cycle: mem_ack wins.
REQ-025 DECODE: bus_req=read_pc=mem_rd=0, instr_valid=1 for exactly one cycle; -> UPDATE.
REQ-026 UPDATE, single cycle; set_pc and inc_pc are never high together.
- branch_taken=1: set_pc=1, counter_input=branch_target.
- Otherwise: inc_pc=1, increment_amount=instr_len; instr_len=0 is forced to 1.
REQ-027 UPDATE exit: halt pending -> HALT; otherwise -> REQ.
REQ-028 halt_req is latched in any state except IDLE, HALT and FAULT; the latch clears on entry to HALT.
REQ-029 halt_req is ignored in IDLE, HALT and FAULT.
REQ-030 HALT: halted=1; start=1 -> REQ.
REQ-031 FAULT: fault=1, bus released, strobes low; start=1 -> REQ, PC unchanged (retry).
REQ-032 Fetch latency with immediate grant and ack: start edge to first set_pc/inc_pc is 4 cycles (REQ, ADDR, DECODE, UPDATE).
REQ-033 counter_input and increment_amount are 0 whenever their strobe is low.

Reset
REQ-034 reset_n=0 immediately forces IDLE, clears the halt latch and the timeout counter, and drives every output to 0.
REQ-035 Reset asserted mid-fetch drops bus_req, read_pc and mem_rd asynchronously, with no glitch back to 1 until start.

Configuration
REQ-036 GPU_FETCH_TIMEOUT_EN defined:
- An 8-bit counter clears on ADDR entry and increments each ADDR cycle without mem_ack.
- Reaching TIMEOUT_CYCLES -> FAULT.
REQ-037 GPU_FETCH_TIMEOUT_EN undefined: no counter; ADDR waits indefinitely; FAULT is unreachable and fault is tied to 0.

Verification
REQ-038 Reset, start=1, bus_gnt and mem_ack given in first ADDR cycle, instr_len=3, branch_taken=0 -> instr_valid one pulse, then inc_pc=1 with increment_amount=3, 4 cycles after start.
REQ-039 branch_taken=1, branch_target=0x1ABC -> set_pc=1, counter_input=0x1ABC, inc_pc=0; next cycle back in REQ.
REQ-040 bus_gnt dropped in 2nd ADDR cycle, mem_ack=0 -> read_pc=0 next cycle, bus_req stays 1, fetch retried, no PC strobe.
REQ-041 halt_req pulsed during ADDR -> instruction completes with one inc_pc, then halted=1; start -> REQ.
REQ-042 With GPU_FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=4, mem_ack held low -> fault=1 after 4 ADDR cycles, bus_req=0; start clears fault and refetches.
REQ-043 reset_n low during ADDR -> bus_req, read_pc and mem_rd go to 0 before the next clk edge; halt latch is clear after release.

Source files
------------

// File: rtl/gpu_fetch_ctrl.sv
// rtl/gpu_fetch_ctrl.sv - instruction fetch sequencer for the shared-bus GPU front end
// Optional ADDR-state watchdog enabled by defining GPU_FETCH_TIMEOUT_EN.
module gpu_fetch_ctrl #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        halt_req,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic        read_pc,
  output logic        mem_rd,
  input  logic        mem_ack,
  output logic        instr_valid,
  input  logic [7:0]  instr_len,
  input  logic        branch_taken,
  input  logic [12:0] branch_target,
  output logic        set_pc,
  output logic        inc_pc,
  output logic [12:0] counter_input,
  output logic [7:0]  increment_amount,
  output logic        halted,
  output logic        fault
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REQ    = 3'd1;
  localparam logic [2:0] S_ADDR   = 3'd2;
  localparam logic [2:0] S_DECODE = 3'd3;
  localparam logic [2:0] S_UPDATE = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;
  localparam logic [2:0] S_FAULT  = 3'd6;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("gpu_fetch_ctrl: TIMEOUT_CYCLES out of range 2..255");
  end

  logic [2:0] state, state_nx;
  logic       halt_lat;
  logic       halt_pend;
  logic       active;
  logic       timeout;

  // halt_req only counts while a fetch sequence is running
  assign active    = (state != S_IDLE) && (state != S_HALT) && (state != S_FAULT);
  assign halt_pend = halt_lat || halt_req;

`ifdef GPU_FETCH_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] tcnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tcnt <= 8'd0;
    end else if (state != S_ADDR) begin
      tcnt <= 8'd0;
    end else if (!mem_ack) begin
      tcnt <= tcnt + 8'd1;
    end
  end

  assign timeout = (tcnt == TMO_LAST);
  assign fault   = (state == S_FAULT);
`else
  assign timeout = 1'b0;
  assign fault   = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start) state_nx = S_REQ;
      S_REQ:    if (bus_gnt) state_nx = S_ADDR;
      S_ADDR: begin
        // an ack in the same cycle as a lost grant still completes the read
        if (mem_ack)       state_nx = S_DECODE;
        else if (!bus_gnt) state_nx = S_REQ;
        else if (timeout)  state_nx = S_FAULT;
      end
      S_DECODE: state_nx = S_UPDATE;
      S_UPDATE: state_nx = halt_pend ? S_HALT : S_REQ;
      S_HALT:   if (start) state_nx = S_REQ;
      S_FAULT:  if (start) state_nx = S_REQ;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      halt_lat <= 1'b0;
    end else begin
      state <= state_nx;
      if (state_nx == S_HALT)
        halt_lat <= 1'b0;
      else if (active && halt_req)
        halt_lat <= 1'b1;
    end
  end

  // Outputs decode the state register only, so reset kills them without waiting for a clock
  assign bus_req     = (state == S_REQ) || (state == S_ADDR);
  assign read_pc     = (state == S_ADDR);
  assign mem_rd      = (state == S_ADDR);
  assign instr_valid = (state == S_DECODE);
  assign halted      = (state == S_HALT);
  assign set_pc      = (state == S_UPDATE) && branch_taken;
  assign inc_pc      = (state == S_UPDATE) && !branch_taken;

  assign counter_input    = set_pc ? branch_target : 13'd0;
  assign increment_amount = !inc_pc ? 8'd0 : ((instr_len == 8'd0) ? 8'd1 : instr_len);

endmodule

// File: tb/tb_gpu_fetch_ctrl.sv
// tb/tb_gpu_fetch_ctrl.sv - directed self-checking bench for gpu_fetch_ctrl
module tb_gpu_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        halt_req = 1'b0;
  logic        bus_req;
  logic        bus_gnt = 1'b0;
  logic        read_pc;
  logic        mem_rd;
  logic        mem_ack = 1'b0;
  logic        instr_valid;
  logic [7:0]  instr_len = 8'd0;
  logic        branch_taken = 1'b0;
  logic [12:0] branch_target = 13'd0;
  logic        set_pc;
  logic        inc_pc;
  logic [12:0] counter_input;
  logic [7:0]  increment_amount;
  logic        halted;
  logic        fault;

  int n_chk = 0;
  int n_fail = 0;

  gpu_fetch_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .halt_req(halt_req),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .read_pc(read_pc), .mem_rd(mem_rd),
    .mem_ack(mem_ack), .instr_valid(instr_valid), .instr_len(instr_len),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .set_pc(set_pc), .inc_pc(inc_pc), .counter_input(counter_input),
    .increment_amount(increment_amount), .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_bus_req", bus_req, 0);
    chk("rst_read_pc", read_pc, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_halted", halted, 0);
    chk("rst_fault", fault, 0);
    chk("rst_inc_pc", inc_pc, 0);
    step(); step();
    @(negedge clk);
    reset_n = 1'b1;
    halt_req = 1'b1;
    step();
    chk("idle_ignores_halt", bus_req, 0);
    halt_req = 1'b0;

    // straight fetch, instr_len=3
    start = 1'b1; bus_gnt = 1'b1; mem_ack = 1'b1; instr_len = 8'd3;
    step();
    chk("f1_req_bus_req", bus_req, 1);
    chk("f1_req_read_pc", read_pc, 0);
    start = 1'b0;
    step();
    chk("f1_addr_read_pc", read_pc, 1);
    chk("f1_addr_mem_rd", mem_rd, 1);
    chk("f1_addr_bus_req", bus_req, 1);
    step();
    chk("f1_dec_valid", instr_valid, 1);
    chk("f1_dec_bus_req", bus_req, 0);
    chk("f1_dec_inc_pc", inc_pc, 0);
    step();
    chk("f1_upd_valid", instr_valid, 0);
    chk("f1_upd_inc_pc", inc_pc, 1);
    chk("f1_upd_amount", increment_amount, 3);
    chk("f1_upd_set_pc", set_pc, 0);
    chk("f1_upd_cin", counter_input, 0);
    step();
    chk("f1_back_req", bus_req, 1);
    chk("f1_back_inc", inc_pc, 0);
    chk("f1_back_amount", increment_amount, 0);

    // taken branch
    branch_taken = 1'b1; branch_target = 13'h1ABC;
    step(); step(); step();
    chk("br_set_pc", set_pc, 1);
    chk("br_cin", counter_input, 32'h1ABC);
    chk("br_inc_pc", inc_pc, 0);
    chk("br_amount", increment_amount, 0);
    step();
    chk("br_back_req", bus_req, 1);
    chk("br_back_rd", read_pc, 0);
    chk("br_back_set", set_pc, 0);
    branch_taken = 1'b0;

    // grant lost in 2nd ADDR cycle, then retry with instr_len=0
    mem_ack = 1'b0;
    step();
    chk("ab_addr1_rd", read_pc, 1);
    step();
    chk("ab_addr2_rd", read_pc, 1);
    bus_gnt = 1'b0;
    step();
    chk("ab_req_rd", read_pc, 0);
    chk("ab_req_bus", bus_req, 1);
    chk("ab_no_inc", inc_pc, 0);
    chk("ab_no_set", set_pc, 0);
    bus_gnt = 1'b1; mem_ack = 1'b1; instr_len = 8'd0;
    step(); step(); step();
    chk("len0_inc", inc_pc, 1);
    chk("len0_amount", increment_amount, 1);
    step();

    // halt request pulsed during ADDR
    mem_ack = 1'b0; instr_len = 8'd5;
    step();
    halt_req = 1'b1;
    step();
    chk("h_still_addr", read_pc, 1);
    halt_req = 1'b0; mem_ack = 1'b1;
    step(); step();
    chk("h_upd_inc", inc_pc, 1);
    chk("h_upd_amount", increment_amount, 5);
    chk("h_upd_halted", halted, 0);
    step();
    chk("h_halted", halted, 1);
    chk("h_bus_req", bus_req, 0);
    halt_req = 1'b1;
    step();
    chk("h_stays", halted, 1);
    halt_req = 1'b0; start = 1'b1;
    step();
    chk("h_resume_halted", halted, 0);
    chk("h_resume_req", bus_req, 1);
    start = 1'b0;

    // ack wins over dropped grant; halt latch must be clear now
    mem_ack = 1'b0;
    step();
    bus_gnt = 1'b0; mem_ack = 1'b1;
    step();
    chk("ackwin_valid", instr_valid, 1);
    bus_gnt = 1'b1;
    step(); step();
    chk("ackwin_not_halt", halted, 0);
    chk("ackwin_req", bus_req, 1);

    // asynchronous reset mid-ADDR with halt latched
    mem_ack = 1'b0;
    step();
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_bus_req", bus_req, 0);
    chk("ar_read_pc", read_pc, 0);
    chk("ar_mem_rd", mem_rd, 0);
    step();
    chk("ar_hold_bus", bus_req, 0);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    chk("ar_idle_no_start", bus_req, 0);
    start = 1'b1; mem_ack = 1'b1; instr_len = 8'd2;
    step();
    start = 1'b0;
    step(); step(); step();
    chk("ar_upd_amount", increment_amount, 2);
    step();
    chk("ar_latch_clear", halted, 0);
    chk("ar_back_req", bus_req, 1);

`ifdef GPU_FETCH_TIMEOUT_EN
    // watchdog: four ADDR cycles without ack then FAULT
    mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("to_addr_rd", read_pc, 1);
    end
    step();
    chk("to_fault", fault, 1);
    chk("to_bus_req", bus_req, 0);
    chk("to_read_pc", read_pc, 0);
    step();
    chk("to_fault_hold", fault, 1);
    start = 1'b1; mem_ack = 1'b1;
    step();
    chk("to_clear", fault, 0);
    chk("to_refetch", bus_req, 1);
    start = 1'b0;
    step(); step();
    chk("to_refetch_valid", instr_valid, 1);
`else
    // no watchdog: ADDR waits indefinitely
    mem_ack = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("nt_still_addr", read_pc, 1);
    chk("nt_no_fault", fault, 0);
    mem_ack = 1'b1;
    step();
    chk("nt_late_ack", instr_valid, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
